// File: rtl/mem_responder.sv
// Word-addressed memory slave with a ready/valid style request handshake, a
// programmable read latency, and range/conflict error reporting.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              write_ack,
    output logic              err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state, w_nextState;
    logic [3:0]        r_cnt, w_nextCnt;
    logic [ADDR_W-1:0] r_addr, w_nextAddr;
    logic [DATA_W-1:0] r_rdata, w_nextRdata;
    logic              r_valid, r_ack, r_err;
    logic              w_nextValid, w_nextAck, w_nextErr;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memWAddr;
    logic [DATA_W-1:0] w_memWData;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_rdOk, w_reqOk, w_loadOk;
    logic [DATA_W-1:0] w_rdWord;

    // In IDLE a zero-latency read uses the live address; later it uses the latched one.
    assign w_rdAddr = (r_state == S_IDLE) ? addr : r_addr;
    assign w_rdOk   = {1'b0, w_rdAddr} < DEPTH_L;
    assign w_reqOk  = {1'b0, addr} < DEPTH_L;
    assign w_loadOk = {1'b0, load_addr} < DEPTH_L;
    assign w_rdWord = w_rdOk ? r_mem[w_rdAddr[IDX_W-1:0]] : '0;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextAddr  = r_addr;
        w_nextRdata = r_rdata;
        w_nextValid = 1'b0;
        w_nextAck   = 1'b0;
        w_nextErr   = 1'b0;
        w_memWe     = 1'b0;
        w_memWAddr  = addr;
        w_memWData  = wdata;
        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    w_memWe    = w_loadOk;
                    w_memWAddr = load_addr;
                    w_memWData = load_data;
                end else if (read_mem && write_mem) begin
                    w_nextErr = 1'b1;
                end else if (write_mem) begin
                    w_memWe   = w_reqOk;
                    w_nextAck = w_reqOk;
                    w_nextErr = !w_reqOk;
                end else if (read_mem) begin
                    w_nextAddr = addr;
                    if (WAIT_CYCLES == 0) begin
                        w_nextState = S_RESP;
                        w_nextRdata = w_rdWord;
                        w_nextValid = 1'b1;
                        w_nextErr   = !w_rdOk;
                    end else begin
                        w_nextState = S_WAIT;
                        w_nextCnt   = WAIT_L;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_nextState = S_RESP;
                    w_nextCnt   = 4'd0;
                    w_nextRdata = w_rdWord;
                    w_nextValid = 1'b1;
                    w_nextErr   = !w_rdOk;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_addr  <= w_nextAddr;
            r_rdata <= w_nextRdata;
            r_valid <= w_nextValid;
            r_ack   <= w_nextAck;
            r_err   <= w_nextErr;
        end
    end

    // Storage survives reset, but nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset && w_memWe) begin
            r_mem[w_memWAddr[IDX_W-1:0]] <= w_memWData;
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign rdata       = r_rdata;
    assign rdata_valid = r_valid;
    assign write_ack   = r_ack;
    assign err         = r_err;

endmodule
